// File: rtl/psk_frame_pkg.sv
// Shared types and constants for the PSK frame builder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psk_frame_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PREAMBLE,
        ST_SYNC_HI,
        ST_SYNC_LO,
        ST_LEN,
        ST_PAYLOAD,
        ST_CRC
    } frame_state_t;

    localparam logic [7:0]  CRC8_POLY             = 8'h07;
    localparam logic [15:0] DEFAULT_SYNC_WORD     = 16'hD391;
    localparam logic [7:0]  DEFAULT_PREAMBLE_BYTE = 8'h55;

endpackage

// File: rtl/psk_crc8_byte.sv
// Next CRC-8 (poly 0x07, MSB-first, unreflected) after folding in one byte.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module psk_crc8_byte
    import psk_frame_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] r;

    // Eight unrolled shift/XOR steps over the byte merged into the running CRC
    always_comb begin
        r = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ CRC8_POLY) : {r[6:0], 1'b0};
        end
        crc_out = r;
    end

endmodule

// File: rtl/psk_frame_builder.sv
// Buffers one payload, then emits preamble, sync word, length, payload [, CRC-8 when PSK_FRAME_CRC_EN].
// Latency: first preamble byte valid the cycle after the closing payload byte is accepted; 1 byte/cycle.
// Backpressure: outputs held while psk_tready is low; input is only accepted while idle (no fill/send overlap).
module psk_frame_builder
    import psk_frame_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [7:0]  PREAMBLE_BYTE = DEFAULT_PREAMBLE_BYTE,
    parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
    parameter int unsigned MAX_PAYLOAD   = 64
)(
    input  logic        clk_1d024M,
    input  logic        rst_n_1d024M,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  psk_tdata,
    output logic        psk_tvalid,
    input  logic        psk_tready,
    output logic        psk_tuser,
    output logic        psk_tlast,
    output logic        frame_busy,
    output logic [15:0] frame_cnt
);

    localparam int unsigned AW        = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [3:0]  PRE_LAST  = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  FILL_LAST = 8'(MAX_PAYLOAD - 1);

    frame_state_t state;
    logic [7:0]   payload_buf [0:MAX_PAYLOAD-1];
    logic [7:0]   wr_ptr;
    logic [7:0]   rd_ptr;
    logic [7:0]   len;
    logic [3:0]   pre_cnt;
    logic         in_hs;
    logic         out_hs;
    logic         fill_done;
    logic [7:0]   rd_dat;

    assign in_hs     = s_tvalid && s_tready;
    assign out_hs    = psk_tvalid && psk_tready;
    assign fill_done = s_tlast || (wr_ptr == FILL_LAST);
    // rd_ptr is the registered read address; it already points at the next payload beat
    assign rd_dat    = payload_buf[rd_ptr[AW-1:0]];

`ifdef PSK_FRAME_CRC_EN
    logic [7:0] crc;
    logic [7:0] crc_next;

    // psk_tdata holds the LEN or payload byte being handshaked, so it feeds the CRC directly
    psk_crc8_byte u_crc (
        .crc_in  (crc),
        .byte_in (psk_tdata),
        .crc_out (crc_next)
    );
`else
    logic next_is_last;

    // True when the beat about to be loaded (index rd_ptr) is the final payload byte
    assign next_is_last = (rd_ptr == len - 8'd1);
`endif

    // Payload buffer write port; contents need no reset since len gates every read
    always_ff @(posedge clk_1d024M) begin
        if (rst_n_1d024M && in_hs) begin
            payload_buf[wr_ptr[AW-1:0]] <= s_tdata;
        end
    end

    // Frame sequencer: fill, then walk the header, payload and optional CRC on output handshakes
    always_ff @(posedge clk_1d024M) begin
        if (!rst_n_1d024M) begin
            state      <= ST_FILL;
            s_tready   <= 1'b0;
            psk_tvalid <= 1'b0;
            psk_tdata  <= 8'h00;
            psk_tuser  <= 1'b0;
            psk_tlast  <= 1'b0;
            frame_busy <= 1'b0;
            frame_cnt  <= 16'h0000;
            wr_ptr     <= 8'h00;
            rd_ptr     <= 8'h00;
            len        <= 8'h00;
            pre_cnt    <= 4'h0;
`ifdef PSK_FRAME_CRC_EN
            crc        <= 8'h00;
`endif
        end else begin
            case (state)
                ST_FILL: begin
                    s_tready <= 1'b1;
`ifdef PSK_FRAME_CRC_EN
                    crc      <= 8'h00;
`endif
                    if (in_hs) begin
                        wr_ptr <= wr_ptr + 8'd1;
                        if (fill_done) begin
                            // Truncation and s_tlast both close the frame; leftovers start the next one
                            len        <= wr_ptr + 8'd1;
                            wr_ptr     <= 8'h00;
                            rd_ptr     <= 8'h00;
                            pre_cnt    <= 4'h0;
                            s_tready   <= 1'b0;
                            frame_busy <= 1'b1;
                            psk_tvalid <= 1'b1;
                            psk_tdata  <= PREAMBLE_BYTE;
                            psk_tuser  <= 1'b1;
                            state      <= ST_PREAMBLE;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (out_hs) begin
                        psk_tuser <= 1'b0;
                        if (pre_cnt == PRE_LAST) begin
                            psk_tdata <= SYNC_WORD[15:8];
                            state     <= ST_SYNC_HI;
                        end else begin
                            pre_cnt <= pre_cnt + 4'd1;
                        end
                    end
                end
                ST_SYNC_HI: begin
                    if (out_hs) begin
                        psk_tdata <= SYNC_WORD[7:0];
                        state     <= ST_SYNC_LO;
                    end
                end
                ST_SYNC_LO: begin
                    if (out_hs) begin
                        psk_tdata <= len;
                        state     <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (out_hs) begin
                        psk_tdata <= rd_dat;
                        rd_ptr    <= rd_ptr + 8'd1;
                        state     <= ST_PAYLOAD;
`ifdef PSK_FRAME_CRC_EN
                        crc       <= crc_next;
`else
                        psk_tlast <= next_is_last;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (out_hs) begin
                        if (rd_ptr == len) begin
`ifdef PSK_FRAME_CRC_EN
                            psk_tdata <= crc_next;
                            psk_tlast <= 1'b1;
                            state     <= ST_CRC;
`else
                            psk_tvalid <= 1'b0;
                            psk_tdata  <= 8'h00;
                            psk_tlast  <= 1'b0;
                            frame_busy <= 1'b0;
                            s_tready   <= 1'b1;
                            rd_ptr     <= 8'h00;
                            frame_cnt  <= frame_cnt + 16'd1;
                            state      <= ST_FILL;
`endif
                        end else begin
                            psk_tdata <= rd_dat;
                            rd_ptr    <= rd_ptr + 8'd1;
`ifndef PSK_FRAME_CRC_EN
                            psk_tlast <= next_is_last;
`endif
                        end
`ifdef PSK_FRAME_CRC_EN
                        crc <= crc_next;
`endif
                    end
                end
`ifdef PSK_FRAME_CRC_EN
                ST_CRC: begin
                    if (out_hs) begin
                        psk_tvalid <= 1'b0;
                        psk_tdata  <= 8'h00;
                        psk_tlast  <= 1'b0;
                        frame_busy <= 1'b0;
                        s_tready   <= 1'b1;
                        rd_ptr     <= 8'h00;
                        crc        <= 8'h00;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= ST_FILL;
                    end
                end
`endif
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psk_frame_builder.sv
// Randomised bench for psk_frame_builder with a frame-level reference model and scoreboard.
// Covers reset, directed CRC vector, truncation, stalls, reset mid-frame and frame counter wrap.
// Works with PSK_FRAME_CRC_EN either defined or not.
`timescale 1ns/1ps
module tb_psk_frame_builder;

    localparam int PRE_LEN = 4;
    localparam int MAXP    = 64;
`ifdef PSK_FRAME_CRC_EN
    localparam int CRCB = 1;
`else
    localparam int CRCB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [7:0]  psk_tdata;
    logic        psk_tvalid;
    logic        psk_tready;
    logic        psk_tuser;
    logic        psk_tlast;
    logic        frame_busy;
    logic [15:0] frame_cnt;

    psk_frame_builder #(
        .PREAMBLE_LEN (PRE_LEN),
        .MAX_PAYLOAD  (MAXP)
    ) dut (
        .clk_1d024M   (clk),
        .rst_n_1d024M (rst_n),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .psk_tdata    (psk_tdata),
        .psk_tvalid   (psk_tvalid),
        .psk_tready   (psk_tready),
        .psk_tuser    (psk_tuser),
        .psk_tlast    (psk_tlast),
        .frame_busy   (frame_busy),
        .frame_cnt    (frame_cnt)
    );

    initial forever #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];   // {tuser, tlast, data} per expected beat
    logic [7:0] cap_q[$];   // every handshaked output byte
    int         exp_frames = 0;
    int         rdy_pct = 100;
    bit         mon_en = 0;
    int         hs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial polynomial division over the whole LEN+payload sequence
    function automatic logic [7:0] ref_crc(input logic [7:0] bytes[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (bytes[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ bytes[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Split a message into MAXP-sized frames and queue the expected beats of each
    task automatic model_msg(input logic [7:0] msg[$]);
        logic [7:0] body[$];
        int pos = 0;
        int n;
        while (pos < msg.size()) begin
            n = msg.size() - pos;
            if (n > MAXP) n = MAXP;
            for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({(i == 0), 1'b0, 8'h55});
            exp_q.push_back({2'b00, 8'hD3});
            exp_q.push_back({2'b00, 8'h91});
            body.delete();
            body.push_back(8'(n));
            for (int i = 0; i < n; i++) body.push_back(msg[pos + i]);
            for (int i = 0; i < body.size(); i++)
                exp_q.push_back({1'b0, (CRCB == 0) && (i == body.size() - 1), body[i]});
            if (CRCB != 0) exp_q.push_back({2'b01, ref_crc(body)});
            exp_frames++;
            pos += n;
        end
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        int i = 0;
        int chunk = 0;
        int guard = 0;
        bit acc;
        bit closes;
        model_msg(msg);
        while (i < msg.size() && guard < 5000) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = msg[i];
            s_tlast  = (i == msg.size() - 1);
            @(negedge clk);
            acc = s_tvalid && s_tready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                closes = s_tlast || (chunk == MAXP - 1);
                i++;
                chunk = closes ? 0 : chunk + 1;
                if (closes)
                    chk("frame_start", {psk_tvalid, psk_tuser, psk_tdata}, {1'b1, 1'b1, 8'h55});
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (guard >= 5000) chk("send_timeout", guard, 0);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || frame_busy) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 3000) chk({tag, "_timeout"}, g, 0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_frame_cnt"}, frame_cnt, 32'(16'(exp_frames)));
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk); #1;
            psk_tready = (int'($urandom_range(0, 99)) < rdy_pct);
        end
    endtask

    // Scoreboard plus protocol checks, sampled on the falling edge
    task automatic monitor();
        logic [9:0] e;
        logic [9:0] prev_out = '0;
        bit prev_stall = 0;
        bit in_frame = 0;
        bit after_last = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 0;
                in_frame   = 0;
                after_last = 0;
            end else begin
                if (after_last)
                    chk("idle_after_last", {psk_tvalid, s_tready, frame_busy}, 3'b010);
                if (prev_stall)
                    chk("stall_hold", {psk_tvalid, psk_tuser, psk_tlast, psk_tdata}, {1'b1, prev_out});
                else if (in_frame)
                    chk("tvalid_hold", psk_tvalid, 1);
                if (frame_busy && s_tready) chk("no_overlap", s_tready, 0);
                after_last = 0;
                prev_stall = psk_tvalid && !psk_tready;
                prev_out   = {psk_tuser, psk_tlast, psk_tdata};
                if (psk_tvalid && psk_tready) begin
                    hs_cnt++;
                    cap_q.push_back(psk_tdata);
                    if (exp_q.size() == 0) begin
                        chk("beat_pending", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {psk_tuser, psk_tlast, psk_tdata}, e);
                    end
                    if (psk_tlast) begin
                        in_frame   = 0;
                        after_last = 1;
                    end else begin
                        in_frame = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] msg[$];
        logic [7:0] dir[$];
        int base;
        int g;
        int f1;

        s_tvalid   = 1'b0;
        s_tdata    = 8'h00;
        s_tlast    = 1'b0;
        psk_tready = 1'b0;
        rst_n      = 1'b0;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {s_tready, psk_tvalid, psk_tuser, psk_tlast, frame_busy}, 0);
        chk("rst_tdata", psk_tdata, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst_n  = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;
        chk("fill_ready", s_tready, 1);

        // Directed single-byte frame against the literal expected stream
        cap_q.delete();
        msg = {8'h00};
        send_msg(msg);
        wait_done("single");
`ifdef PSK_FRAME_CRC_EN
        dir = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h01, 8'h00, 8'h15};
`else
        dir = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h01, 8'h00};
`endif
        chk("single_beats", cap_q.size(), dir.size());
        foreach (dir[i]) if (i < cap_q.size()) chk("single_byte", cap_q[i], dir[i]);

        // 70-byte message truncated into 64 + 6
        cap_q.delete();
        msg.delete();
        for (int i = 0; i < 70; i++) msg.push_back(8'(i));
        send_msg(msg);
        wait_done("trunc");
        f1 = PRE_LEN + 3 + MAXP + CRCB;
        if (cap_q.size() > f1 + PRE_LEN + 2) begin
            chk("trunc_len1", cap_q[PRE_LEN + 2], 8'h40);
            chk("trunc_len2", cap_q[f1 + PRE_LEN + 2], 8'h06);
        end else begin
            chk("trunc_beats", cap_q.size(), f1 + PRE_LEN + 3);
        end

        // Exactly MAX_PAYLOAD bytes closed by s_tlast on the last slot
        msg.delete();
        for (int i = 0; i < MAXP; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        wait_done("exact_max");

        // 10-byte frame with 50% output backpressure
        rdy_pct = 50;
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        wait_done("stall10");

        // Random lengths and backpressure
        for (int k = 0; k < 6; k++) begin
            rdy_pct = $urandom_range(30, 100);
            msg.delete();
            g = $urandom_range(1, 140);
            for (int i = 0; i < g; i++) msg.push_back(8'($urandom));
            send_msg(msg);
            wait_done("random");
        end

        // Reset while payload beat 3 is on the output
        rdy_pct = 100;
        repeat (3) @(posedge clk);
        #1;
        base = hs_cnt;
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        g = 0;
        while ((hs_cnt - base) < PRE_LEN + 6 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("pre_reset_beat", psk_tdata, msg[3]);
        rst_n  = 1'b0;
        mon_en = 0;
        @(posedge clk); #1;
        chk("midrst_ctrl", {s_tready, psk_tvalid, psk_tuser, psk_tlast, frame_busy}, 0);
        chk("midrst_tdata", psk_tdata, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        exp_frames = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        wait_done("post_reset");

        // Frame counter wrap from 0xFFFF
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt;
        @(posedge clk); #1;
        chk("backdoor", frame_cnt, 16'hFFFF);
        exp_frames = 32'hFFFF;
        msg = {8'hA5};
        send_msg(msg);
        wait_done("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psk_frame_builder.md
# psk_frame_builder

Packetiser directly upstream of the PSK modulator. Collects a payload from an AXI-Stream byte source, buffers it, and emits a framed byte stream: preamble, sync word, length byte, payload, optional CRC-8. The output is the modulator's `psk_*` byte input, including handshake, start-of-frame (`tuser`) and end-of-frame (`tlast`) markers. Runs in the 1.024 MHz symbol-side domain.

## Interface
Parameters:
- `PREAMBLE_LEN`, default 4: number of preamble bytes, range 1..15.
- `PREAMBLE_BYTE`, default 8'h55: preamble pattern.
- `SYNC_WORD`, default 16'hD391: sync word, sent MSB byte first.
- `MAX_PAYLOAD`, default 64: buffer depth in bytes, range 1..255.

Ports:
- `clk_1d024M`, in, 1: sole clock.
- `rst_n_1d024M`, in, 1: reset, synchronous, active-low.
- `s_tdata`, in, 8: payload byte.
- `s_tvalid`, in, 1: payload valid.
- `s_tlast`, in, 1: last payload byte of a message.
- `s_tready`, out, 1: payload accept.
- `psk_tdata`, out, 8: framed byte.
- `psk_tvalid`, out, 1: framed byte valid.
- `psk_tready`, in, 1: modulator accept.
- `psk_tuser`, out, 1: high on the first preamble byte only.
- `psk_tlast`, out, 1: high on the final byte of the frame.
- `frame_busy`, out, 1: high in every state except FILL.
- `frame_cnt`, out, 16: count of completed frames; wraps at 0xFFFF→0.

## Operation
- FSM states: FILL, PREAMBLE, SYNC_HI, SYNC_LO, LEN, PAYLOAD, CRC.
- **FILL**
  - `s_tready`=1.
  - Each `s_tvalid&&s_tready` writes `buf[wr_ptr]` and increments `wr_ptr`.
  - Leave FILL on acceptance of a byte with `s_tlast`=1, or on acceptance of byte number `MAX_PAYLOAD` (truncation).
  - After truncation, the remaining input bytes form the next frame.
  - Length L = number of bytes accepted. L is never 0.
- **Transmit sequence:** PREAMBLE (`PREAMBLE_LEN` beats) → SYNC_HI → SYNC_LO → LEN (`tdata`=L) → PAYLOAD (L beats, `buf[0..L-1]`) → CRC → FILL.
  - Each state advances only on an output handshake (`psk_tvalid&&psk_tready`).
- **CRC-8:** polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Covers the LEN byte and the payload bytes.
  - Updated on each handshake of those bytes. Cleared in FILL.
- `frame_cnt` increments on the handshake of the `tlast` byte.
- **Reset values:** state=FILL, `s_tready`=0 during reset then 1, `psk_tvalid`=0, `psk_tdata`=0, `psk_tuser`=0, `psk_tlast`=0, `frame_busy`=0, `frame_cnt`=0, pointers and CRC 0.
- **Reset mid-frame:** the frame is abandoned and the buffer contents are discarded. No partial `tlast` is ever emitted.

## Timing
- All outputs are registered.
- **Frame start:** the cycle after the closing payload byte is accepted, `psk_tvalid`=1 with `tdata`=`PREAMBLE_BYTE` and `psk_tuser`=1.
- **Stalls:** `psk_tdata`, `psk_tuser` and `psk_tlast` are held stable while `psk_tvalid&&!psk_tready`. `psk_tvalid` never drops mid-frame.
- **Throughput:** one byte per cycle when `psk_tready` is held high. Frame length is `PREAMBLE_LEN`+4+L beats with CRC, +3+L without.
- **Returning to FILL:** `psk_tvalid`=0 the cycle after the `tlast` handshake. `s_tready`=1 in the same cycle.
- There is no overlap between fill and transmit: `s_tready`=0 whenever `frame_busy`=1.
- **Buffer:** read address is registered. The PAYLOAD read for beat k+1 is issued on the handshake of beat k, so there are no bubbles.

## Configuration
- `PSK_FRAME_CRC_EN` defined:
  - The CRC state is present.
  - `psk_tlast` is on the CRC byte.
- `PSK_FRAME_CRC_EN` undefined:
  - The CRC state and CRC logic are removed.
  - `psk_tlast` is on the last payload byte.
  - PAYLOAD → FILL directly.

## Structure
- **Package `psk_frame_pkg`:** FSM state enum, `CRC8_POLY`=8'h07, default `SYNC_WORD`, default `PREAMBLE_BYTE`.
- **Sub-module `psk_crc8_byte`:** combinational next-CRC from (`crc_in`, `byte_in`), 8 unrolled shift/XOR steps.
- **Payload buffer:** inferred `MAX_PAYLOAD`×8 register array or distributed RAM inside the block.

## Test plan
- Payload {0x00} with `s_tlast`, `psk_tready`=1, CRC on → 55 55 55 55 D3 91 01 00 15. `tuser` on beat 0, `tlast` on 0x15, `frame_cnt`=1.
- Same payload, CRC macro off → 55 55 55 55 D3 91 01 00. `tlast` on 0x00, 8 beats.
- 70-byte input (bytes 0..69), tlast on byte 69, MAX_PAYLOAD=64 → first frame LEN=0x40 with bytes 0..63, then second frame LEN=0x06 with bytes 64..69. `frame_cnt`=2.
- Random `psk_tready` (50%) during a 10-byte frame → output byte sequence identical to the `tready`=1 case. `tdata` stable during stalls, `tvalid` never drops before `tlast`.
- Assert `rst_n_1d024M`=0 during PAYLOAD beat 3 → next cycle all outputs at reset values. A fresh frame after reset is correct with `frame_cnt`=1.
- `frame_cnt` preloaded near wrap (force 0xFFFF via 65535 short frames or a bench backdoor) → the next frame completes with `frame_cnt`=0x0000.
